sb_config_loader: RTL
=====================

Name: sb_config_loader

Overview:
- Streaming configuration controller for the switch-box array. Accepts a framed 32-bit word stream and unpacks it into per-tile configuration writes.
- Drives a shared config_data bus and a one-hot config_en per switch box, so each tile's 32-bit select register (2-bit mux selects) loads exactly once per addressed word.
- Sits between the off-chip/bitstream interface and the config_data/config_en inputs of every switch box.

Parameters:
- NUM_TILES, 16, number of switch boxes addressed; width of config_en; legal range 1..65535.
- DATA_W, 32, config word width; fixed to 32 (header format depends on it).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- in_data, input, 32, stream word (header or payload).
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, loader can accept a word this cycle.
- hold, input, 1, stall request; forces in_ready low while high.
- clear_err, input, 1, synchronous clear of the sticky err flag.
- config_data, output, 32, shared config bus to all switch boxes.
- config_en, output, NUM_TILES, one-hot write strobe; bit i loads tile i.
- busy, output, 1, high while a frame is open (state DATA).
- done, output, 1, one-cycle pulse at frame completion.
- err, output, 1, sticky out-of-range address flag.
- frame_count, output, 16, number of completed frames; wraps at 2^16.

Behaviour:
- Frame format: header word = {base_addr[31:16], count[15:0]}, followed by exactly count payload words. Payload k (k = 0..count-1) targets tile base_addr+k, computed mod 2^16.
- A transfer occurs on a rising edge with in_valid && in_ready.
- in_ready = !hold in both states. It is purely combinational from hold and has no dependency on in_valid.
- States:
  - HDR: waiting for header.
  - DATA: counting payload words.
- HDR:
  - On transfer, latch cur_addr <= base_addr and remaining <= count.
  - If count != 0, go to DATA.
  - If count == 0, stay in HDR and pulse done the next cycle. frame_count increments.
- DATA:
  - On transfer, register the word: config_data <= in_data on the same edge.
  - If cur_addr < NUM_TILES, config_en <= one-hot(cur_addr). Otherwise config_en <= 0 and err <= 1; the word is consumed and dropped.
  - Then cur_addr <= cur_addr+1 (wraps 0xFFFF->0) and remaining <= remaining-1.
  - When remaining == 1 at transfer, go to HDR. done pulses in the cycle config_en shows the last write, and frame_count increments on the same edge.
- Latency: a payload accepted at edge N drives config_en/config_data during cycle N+1 (1-cycle latency). Back-to-back accepts therefore give back-to-back strobes with no bubble.
- config_en is high for exactly one cycle per accepted in-range payload word, and never has more than one bit set.
- config_data holds its last value when idle. It is not cleared after a write.
- busy = (state == DATA).
- err:
  - Set by any out-of-range payload.
  - Cleared by clear_err only when no set event occurs in the same cycle; set wins on a simultaneous event.
  - Header words never set err.
- hold high mid-frame pauses the frame. State, cur_addr and remaining are preserved, and no config_en fires on cycles without a transfer.
- in_valid low mid-frame behaves the same as hold (no timeout).
- Reset (async, reset == 0), all of the following, regardless of state and including mid-frame:
  - state = HDR, config_data = 0, config_en = 0.
  - done = 0, err = 0, busy = 0, frame_count = 0.
  - cur_addr = 0, remaining = 0.
  - The partial frame is abandoned. The first word after reset release is treated as a header.
- Release is sampled on clk. No transfer occurs on the edge where reset is still low.

Test Plan:
- Reset, then header 0x0003_0002, payloads 0xAAAA5555 and 0x12345678 streamed back-to-back:
  - config_en = 0x0008 with config_data 0xAAAA5555 one cycle after the first accept.
  - Next cycle config_en = 0x0010 with config_data 0x12345678, plus done pulse.
  - frame_count = 1; err = 0.
- Header 0x000F_0003 with NUM_TILES = 16, three payloads:
  - Only tile 15 is written (config_en = 0x8000).
  - Next two words are dropped with config_en = 0 and err = 1.
  - done pulses after the third; err stays 1 until clear_err.
- Header 0x0000_0000:
  - done pulses one cycle after the header; no config_en activity.
  - busy stays 0; frame_count increments.
- Frame of 4 words to base 0 with hold high for 3 cycles after the 2nd payload:
  - in_ready = 0 during hold; no strobes during hold.
  - Remaining strobes hit tiles 2,3 after release; exactly 4 strobes total.
- Assert reset low for 1 cycle after 2 of 5 payloads:
  - All outputs zero immediately (asynchronous).
  - After release, word 0x0001_0001 followed by 0xDEADBEEF produces config_en = 0x0002 and config_data 0xDEADBEEF.
- Same-cycle clear_err and out-of-range write: err remains 1.

Source files
------------

// File: rtl/sb_config_loader_if.sv
// rtl/sb_config_loader_if.sv - stream-in and config-bus signal bundle for sb_config_loader
//
// Signals:
//   in_data/in_valid/in_ready : framed 32-bit word stream (header or payload)
//   config_data               : shared configuration bus to every switch box
//   config_en                 : one-hot write strobe, bit i loads tile i
// Modports:
//   master : bitstream side (drives the stream, observes the config bus)
//   slave  : loader side
interface sb_config_loader_if #(
    parameter int NUM_TILES = 16
) ();
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          config_data;
    logic [NUM_TILES-1:0] config_en;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  config_data,
        input  config_en
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output config_data,
        output config_en
    );
endinterface

// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - unpacks a framed word stream into one-hot per-tile config writes
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   bus         : sb_config_loader_if.slave (in_data/in_valid/in_ready, config_data/config_en)
//   hold        : stall request, forces in_ready low
//   clear_err   : synchronous clear of the sticky err flag
//   busy        : high while a frame is open
//   done        : one-cycle pulse at frame completion
//   err         : sticky out-of-range address flag
//   frame_count : completed frames, wraps at 2^16
module sb_config_loader #(
    parameter int NUM_TILES = 16,
    parameter int DATA_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    sb_config_loader_if.slave         bus,
    input  logic                      hold,
    input  logic                      clear_err,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [15:0]               frame_count
);
    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [NUM_TILES-1:0] EN_ONE    = NUM_TILES'(1);
    localparam logic [16:0]          TILES_LIM = 17'(NUM_TILES);

    state_t                 state_q, state_d;
    logic [15:0]            cur_addr_q, cur_addr_d;
    logic [15:0]            remaining_q, remaining_d;
    logic [DATA_W-1:0]      config_data_q, config_data_d;
    logic [NUM_TILES-1:0]   config_en_q, config_en_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            frame_count_q, frame_count_d;

    logic                   xfer;
    logic                   in_range;

    // Ready depends on hold alone so the upstream never sees a valid->ready loop.
    assign bus.in_ready = !hold;
    assign xfer         = bus.in_valid && !hold;
    // Widened compare keeps NUM_TILES up to 65535 correct against a 16-bit address.
    assign in_range     = ({1'b0, cur_addr_q} < TILES_LIM);

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        config_data_d = config_data_q;
        config_en_d   = '0;
        done_d        = 1'b0;
        err_d         = clear_err ? 1'b0 : err_q;
        frame_count_d = frame_count_q;

        case (state_q)
            HDR: begin
                if (xfer) begin
                    cur_addr_d  = bus.in_data[31:16];
                    remaining_d = bus.in_data[15:0];
                    if (bus.in_data[15:0] != 16'd0) begin
                        state_d = DATA;
                    end else begin
                        // Empty frame completes immediately.
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    config_data_d = bus.in_data;
                    if (in_range) begin
                        config_en_d = EN_ONE << cur_addr_q;
                    end else begin
                        // Set overrides a same-cycle clear_err.
                        err_d = 1'b1;
                    end
                    cur_addr_d  = cur_addr_q + 16'd1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d       = HDR;
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HDR;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            config_data_q <= '0;
            config_en_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            config_data_q <= config_data_d;
            config_en_q   <= config_en_d;
            done_q        <= done_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.config_data = config_data_q;
    assign bus.config_en   = config_en_q;
    assign busy            = (state_q == DATA);
    assign done            = done_q;
    assign err             = err_q;
    assign frame_count     = frame_count_q;
endmodule
